// File: rtl/and_bist_pkg.sv
// rtl/and_bist_pkg.sv - shared types and constants for the AND-cell stuck-at self-test
package and_bist_pkg;

   localparam int NUM_VEC = 4;
   localparam int VEC_W   = 2;
   localparam int FC_W    = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_CLASSIFY,
      ST_DONE
   } state_t;

   localparam logic [FC_W-1:0] FC_OK      = 3'd0;
   localparam logic [FC_W-1:0] FC_A_SA1   = 3'd1;
   localparam logic [FC_W-1:0] FC_B_SA1   = 3'd2;
   localparam logic [FC_W-1:0] FC_SA0_ANY = 3'd3;
   localparam logic [FC_W-1:0] FC_Z_SA1   = 3'd4;
   localparam logic [FC_W-1:0] FC_MULTI   = 3'd5;

endpackage

// File: rtl/and_fault_bist_ctrl_if.sv
// rtl/and_fault_bist_ctrl_if.sv - control and CUT-facing signal bundle of the AND-cell tester
interface and_fault_bist_ctrl_if;
   import and_bist_pkg::*;

   logic                start;
   logic                dut_z;
   logic                test_a;
   logic                test_b;
   logic                busy;
   logic                done;
   logic [NUM_VEC-1:0]  mismatch;
   logic [FC_W-1:0]     fault_class;
   logic [2:0]          err_count;

   modport master (
      output start, dut_z,
      input  test_a, test_b, busy, done, mismatch, fault_class, err_count
   );

   modport slave (
      input  start, dut_z,
      output test_a, test_b, busy, done, mismatch, fault_class, err_count
   );

endinterface

// File: rtl/and_fault_classify.sv
// rtl/and_fault_classify.sv - maps the 4-bit mismatch mask to a single stuck-at fault class
module and_fault_classify
   import and_bist_pkg::*;
(
   input  logic [NUM_VEC-1:0] mismatch,
   output logic [FC_W-1:0]    fault_class
);

   always_comb begin
      fault_class = FC_MULTI;
      case (mismatch)
         4'b0000: fault_class = FC_OK;
         4'b0010: fault_class = FC_A_SA1;
         4'b0100: fault_class = FC_B_SA1;
         4'b1000: fault_class = FC_SA0_ANY;
         4'b0111: fault_class = FC_Z_SA1;
         default: fault_class = FC_MULTI;
      endcase
   end

endmodule

// File: rtl/and_fault_bist_ctrl.sv
// rtl/and_fault_bist_ctrl.sv - clocked exhaustive tester and stuck-at classifier for a 2-input AND cell
module and_fault_bist_ctrl
   import and_bist_pkg::*;
#(
   parameter  int SETTLE_CYCLES = 4,
   localparam int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   and_fault_bist_ctrl_if.slave  bus
);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [VEC_W-1:0]   vec;
   logic               test_a, test_b, busy, done;
   logic [NUM_VEC-1:0] mismatch;
   logic [FC_W-1:0]    fault_class, fc_comb;
   logic [2:0]         err_count;
   logic               accept, settled, last_vec;

   assign accept   = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
   assign settled  = (cnt == CNT_W'(SETTLE_CYCLES - 1));
   assign last_vec = (vec == VEC_W'(NUM_VEC - 1));

   and_fault_classify u_classify (
      .mismatch    (mismatch),
      .fault_class (fc_comb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (accept) state_nxt = ST_SETTLE;
         ST_SETTLE:        if (settled) state_nxt = ST_SAMPLE;
         ST_SAMPLE:        state_nxt = last_vec ? ST_CLASSIFY : ST_SETTLE;
         ST_CLASSIFY:      state_nxt = ST_DONE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   // The applied vector is always {test_a,test_b} == vec, so golden Z is just their AND.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         vec         <= '0;
         test_a      <= 1'b0;
         test_b      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mismatch    <= '0;
         fault_class <= FC_OK;
         err_count   <= '0;
      end else begin
         done <= (state == ST_CLASSIFY);
         if (accept) begin
            vec       <= '0;
            test_a    <= 1'b0;
            test_b    <= 1'b0;
            cnt       <= '0;
            mismatch  <= '0;
            err_count <= '0;
            busy      <= 1'b1;
         end
         case (state)
            ST_SETTLE: cnt <= cnt + 1'b1;
            ST_SAMPLE: begin
               if (bus.dut_z != (test_a & test_b)) begin
                  mismatch[vec] <= 1'b1;
                  err_count     <= err_count + 3'd1;
               end
               if (!last_vec) begin
                  vec               <= vec + 2'd1;
                  {test_a, test_b}  <= vec + 2'd1;
                  cnt               <= '0;
               end
            end
            ST_CLASSIFY: begin
               fault_class <= fc_comb;
               busy        <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.test_a      = test_a;
   assign bus.test_b      = test_b;
   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.mismatch    = mismatch;
   assign bus.fault_class = fault_class;
   assign bus.err_count   = err_count;

endmodule

// File: tb/tb_and_fault_bist_ctrl.sv
// tb/tb_and_fault_bist_ctrl.sv - bench for the AND-cell tester: timeline model plus directed fault runs
module tb_and_fault_bist_ctrl;
   import and_bist_pkg::*;

   localparam int S = 4;
   localparam int P = S + 1;
   localparam int RUN_LEN = 4 * P + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   mode = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   and_fault_bist_ctrl_if bus ();

   and_fault_bist_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 0 good, 1 A sa1, 2 B sa1, 3 Z sa0, 4 Z sa1, 5 inverted output
   function automatic logic faulty_z(input int m, input logic a, input logic b);
      case (m)
         1: return b;
         2: return a;
         3: return 1'b0;
         4: return 1'b1;
         5: return ~(a & b);
         default: return a & b;
      endcase
   endfunction

   function automatic int model_class(input logic [3:0] mask);
      if (mask == 4'b0000) return 0;
      if (mask == 4'b0010) return 1;
      if (mask == 4'b0100) return 2;
      if (mask == 4'b1000) return 3;
      if (mask == 4'b0111) return 4;
      return 5;
   endfunction

   assign bus.dut_z = faulty_z(mode, bus.test_a, bus.test_b);

   // Timeline model: position t counts edges since the start was accepted.
   bit         m_run;
   int         m_t;
   int         m_vec;
   logic [3:0] m_mask;
   bit         m_busy, m_done;
   int         m_fc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run = 0; m_t = 0; m_vec = 0; m_mask = 0;
         m_busy = 0; m_done = 0; m_fc = 0;
      end else if (m_run) begin
         m_t = m_t + 1;
         for (int v = 0; v < 4; v++)
            if (m_t == P * v + P)
               m_mask[v] = (faulty_z(mode, v[1], v[0]) != (v[1] & v[0]));
         m_vec = (m_t / P > 3) ? 3 : m_t / P;
         if (m_t == RUN_LEN) begin
            m_run = 0; m_busy = 0; m_done = 1;
            m_fc = model_class(m_mask);
         end
      end else begin
         m_done = 0;
         if (bus.start) begin
            m_run = 1; m_t = 0; m_vec = 0; m_mask = 0; m_busy = 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_cycle();
      chk("test_a", int'(bus.test_a), m_vec / 2);
      chk("test_b", int'(bus.test_b), m_vec % 2);
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("done", int'(bus.done), int'(m_done));
      chk("mismatch", int'(bus.mismatch), int'(m_mask));
      chk("err_count", int'(bus.err_count), $countones(m_mask));
      chk("fault_class", int'(bus.fault_class), m_fc);
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
   endtask

   task automatic run_test(input int m, input int exp_mask, input int exp_err,
                           input int exp_fc, input int poke_at);
      int n;
      mode = m;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      n = 1;
      while (!bus.done && n < 60) begin
         step();
         n++;
         if (n == poke_at) bus.start = 1'b1;
         if (n == poke_at + 1) bus.start = 1'b0;
      end
      chk("latency", n - 1, 21);
      chk("lit_mismatch", int'(bus.mismatch), exp_mask);
      chk("lit_err_count", int'(bus.err_count), exp_err);
      chk("lit_fault_class", int'(bus.fault_class), exp_fc);
      repeat (3) step();
      chk("hold_ab", int'({bus.test_a, bus.test_b}), 3);
   endtask

   initial begin
      bus.start = 1'b0;
      repeat (2) step();
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_fc", int'(bus.fault_class), 0);
      rst_n = 1'b1;
      step();

      run_test(0, 4'b0000, 0, 0, 0);
      run_test(1, 4'b0010, 1, 1, 0);
      run_test(2, 4'b0100, 1, 2, 0);
      run_test(3, 4'b1000, 1, 3, 0);
      run_test(4, 4'b0111, 3, 4, 0);
      run_test(5, 4'b1111, 4, 5, 0);
      run_test(0, 4'b0000, 0, 0, 12);

      // start held high through DONE: a fresh run begins right after the done pulse
      mode = 4;
      bus.start = 1'b1;
      for (int i = 0; i < 60 && !bus.done; i++) step();
      chk("held_done", int'(bus.done), 1);
      step();
      chk("held_restart_busy", int'(bus.busy), 1);
      chk("held_restart_done", int'(bus.done), 0);
      repeat (3) step();
      bus.start = 1'b0;
      repeat (25) step();

      // reset while sampling vector 1
      mode = 1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (9) step();
      #2 rst_n = 1'b0;
      #1 check_cycle();
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_err", int'(bus.err_count), 0);
      step();
      rst_n = 1'b1;
      step();
      run_test(0, 4'b0000, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
